stego_lsb_embed: RTL and testbench
==================================

Name: stego_lsb_embed

Overview:
- Sits directly downstream of the secret-message FIFO, which delivers 4-bit message nibbles MSB-first, one per accepted read.
- Pulls nibbles from that FIFO and embeds them into the LSBs of a cover-pixel stream, BPP bits per pixel, producing the stego-pixel stream.
- Once the programmed message length is exhausted, cover pixels pass through unchanged.

Parameters:
- PIX_WIDTH, 8, cover/stego pixel width.
- MESS_WIDTH, 4, secret nibble width; must match the FIFO output width.
- BPP, 2, message bits replaced per pixel; legal values 1, 2, 4; must divide MESS_WIDTH.
- LEN_WIDTH, 16, width of message length and counters, in nibbles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; loads msg_len and begins a message.
- msg_len  in  LEN_WIDTH  number of nibbles to embed.
- busy  out  1  high in FETCH, LOAD or EMBED.
- done  out  1  one-cycle pulse when the last nibble's last pixel is accepted, or one cycle after a start with msg_len=0.
- embedded_cnt  out  LEN_WIDTH  nibbles fully embedded since the last start.
- sec_dout  in  MESS_WIDTH  nibble from the FIFO; valid the cycle after a read.
- sec_empty  in  1  FIFO empty.
- sec_rd_req  out  1  FIFO read request.
- pix_in  in  PIX_WIDTH  cover pixel.
- pix_in_valid  in  1  cover pixel valid.
- pix_in_ready  out  1  cover pixel accepted when valid and ready are both high.
- pix_out  out  PIX_WIDTH  stego pixel.
- pix_out_valid  out  1  stego pixel valid.
- pix_out_ready  in  1  downstream accepts.

Behaviour:
- Reset when rst=0 at a clk edge:
  - State goes to IDLE.
  - Outputs pix_out, pix_out_valid, done, embedded_cnt, sec_rd_req and busy are all 0.
  - Internal remaining count, nibble register and slice count clear to 0.
  - Reset mid-message abandons the message; no partial pixel is emitted.
- States: IDLE, FETCH, LOAD, EMBED, PASS.
- start is honoured only in IDLE or PASS; it is ignored in all other states. On start:
  - remaining <= msg_len, embedded_cnt <= 0.
  - If msg_len≠0, go to FETCH.
  - If msg_len=0, go to PASS with a done pulse next cycle.
- FETCH:
  - sec_rd_req = !sec_empty (combinational).
  - When sec_rd_req=1, go to LOAD; otherwise hold indefinitely.
  - sec_rd_req is never high outside FETCH and never high for two consecutive cycles, because the FIFO consumes one nibble per accepted read.
- LOAD:
  - nib_reg <= sec_dout, slice_cnt <= MESS_WIDTH/BPP, go to EMBED.
- EMBED, on an input handshake:
  - pix_out <= {pix_in[PIX_WIDTH-1:BPP], nib_reg[MESS_WIDTH-1 -: BPP]}.
  - nib_reg <<= BPP; slice_cnt decrements.
  - On the last slice: embedded_cnt increments and remaining decrements. If remaining was 1, pulse done and go to PASS; else go to FETCH.
- PASS:
  - Each handshake loads pix_out <= pix_in unchanged.
  - Stays in PASS until start or reset.
- IDLE, FETCH, LOAD: pix_in_ready=0, so the cover stream stalls.
- EMBED, PASS: pix_in_ready = !pix_out_valid || pix_out_ready.
- Output register:
  - Latency is one cycle from input handshake to pix_out_valid.
  - pix_out_valid sets on an input handshake and clears on pix_out_ready with no new handshake.
  - pix_out holds stable while pix_out_valid=1 and pix_out_ready=0.
- Throughput: 2 bubble cycles per nibble (FETCH + LOAD); no look-ahead prefetch.
- FIFO empty mid-message: stall in FETCH, with pix_in_ready=0 and no pixels dropped or passed unmodified.
- Embedding is bitwise replacement only; the upper PIX_WIDTH-BPP bits are untouched. embedded_cnt never exceeds msg_len.

Decomposition:
- Shared package stego_pkg holds:
  - State enumeration (IDLE=0, FETCH=1, LOAD=2, EMBED=3, PASS=4).
  - MESS_WIDTH default of 4, shared with the FIFO.
  - Legal-BPP check constant.
- One natural sub-module: stego_pix_reg, the valid/ready output register stage (pix_out, pix_out_valid, ready generation). The FSM and nibble shifter stay in the top.

Test Plan:
- Reset: drive rst=0 for 3 cycles with random inputs -> all outputs 0, state IDLE, sec_rd_req never high.
- Nominal, BPP=2:
  - Stimulus: FIFO holds word 0xA5000000, start with msg_len=2, pixels 0xFF, 0xFF, 0x00, 0x00, 0x10.
  - Required: pix_out = 0xFE, 0xFE, 0x01, 0x01, 0x10.
  - done pulses once on the 4th pixel handshake; embedded_cnt=2; exactly 2 sec_rd_req pulses.
- FIFO empty stall: sec_empty=1 in FETCH for 20 cycles -> sec_rd_req=0 and pix_in_ready=0 throughout; deassert sec_empty -> sec_rd_req high for exactly 1 cycle, then embedding resumes with the correct nibble.
- Backpressure: pix_out_ready=0 for 5 cycles mid-EMBED -> pix_out and pix_out_valid held, pix_in_ready=0, no pixel lost or duplicated, nibble bits unchanged.
- Zero length: start with msg_len=0 -> no sec_rd_req, done pulse next cycle, pixel 0x37 passes as 0x37.
- Reset mid-EMBED after 1 of 2 slices -> next cycle state IDLE, pix_out_valid=0, embedded_cnt=0, sec_rd_req=0.

Source files
------------

// File: rtl/stego_pkg.sv
// Shared definitions for the LSB steganography embedder.
// Holds the controller state encoding, the nibble width shared with the
// secret-message FIFO and the legal bits-per-pixel check.
package stego_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EMBED = 3'd3,
    PASS  = 3'd4
  } state_t;

  // Nibble width delivered by the secret-message FIFO.
  localparam int unsigned MESS_WIDTH_DEF = 4;

  // Bit n set when n is a legal bits-per-pixel value (1, 2, 4).
  localparam logic [4:0] BPP_LEGAL_SET = 5'b10110;

  // Legal when BPP is one of 1/2/4 and splits a nibble into whole slices.
  function automatic bit bpp_is_legal(input int unsigned bpp,
                                      input int unsigned mess_width);
    if (bpp == 0 || bpp > 4) return 1'b0;
    return BPP_LEGAL_SET[bpp] && ((mess_width % bpp) == 0);
  endfunction

endpackage

// File: rtl/stego_pix_reg.sv
// Valid/ready output register stage for the stego pixel stream.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   accept_en     controller allows new pixels (EMBED or PASS)
//   src_pix       candidate output pixel (already embedded or passthrough)
//   src_valid     upstream pixel valid
//   src_ready     upstream pixel accepted (combinational)
//   pix           registered stego pixel
//   pix_valid     registered stego pixel valid
//   sink_ready    downstream accepts
module stego_pix_reg
  import stego_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept_en,
  input  logic [PIX_WIDTH-1:0] src_pix,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [PIX_WIDTH-1:0] pix,
  output logic                 pix_valid,
  input  logic                 sink_ready
);

  // Accept when the slot is empty or is being drained this cycle.
  assign src_ready = accept_en && (!pix_valid || sink_ready);

  // Single-entry holding register; data is frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix       <= '0;
      pix_valid <= 1'b0;
    end else if (src_valid && src_ready) begin
      pix       <= src_pix;
      pix_valid <= 1'b1;
    end else if (sink_ready) begin
      pix_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stego_lsb_embed.sv
// LSB steganography embedder.
// Pulls 4-bit secret nibbles (MSB-first) from the message FIFO and writes
// them BPP bits at a time into the LSBs of the cover pixel stream. After
// msg_len nibbles are embedded, cover pixels pass through unchanged.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   start, msg_len            begin a message of msg_len nibbles
//   busy, done, embedded_cnt  status
//   sec_dout, sec_empty       FIFO read data (valid cycle after read), empty
//   sec_rd_req                FIFO read request
//   pix_in, pix_in_valid, pix_in_ready      cover pixel stream
//   pix_out, pix_out_valid, pix_out_ready   stego pixel stream
module stego_lsb_embed
  import stego_pkg::*;
#(
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned MESS_WIDTH = MESS_WIDTH_DEF,
  parameter int unsigned BPP        = 2,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  msg_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  embedded_cnt,
  input  logic [MESS_WIDTH-1:0] sec_dout,
  input  logic                  sec_empty,
  output logic                  sec_rd_req,
  input  logic [PIX_WIDTH-1:0]  pix_in,
  input  logic                  pix_in_valid,
  output logic                  pix_in_ready,
  output logic [PIX_WIDTH-1:0]  pix_out,
  output logic                  pix_out_valid,
  input  logic                  pix_out_ready
);

  localparam int unsigned SLICES  = MESS_WIDTH / BPP;
  localparam int unsigned SLICE_W = $clog2(SLICES + 1);

  // Reject illegal slice widths at elaboration.
  if (!bpp_is_legal(BPP, MESS_WIDTH)) begin : g_bad_bpp
    $error("stego_lsb_embed: BPP must be 1, 2 or 4 and divide MESS_WIDTH");
  end

  state_t                state, state_n;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;
  logic [LEN_WIDTH-1:0]  embedded_n;
  logic [MESS_WIDTH-1:0] nib_reg, nib_n;
  logic [SLICE_W-1:0]    slice_cnt, slice_n;
  logic                  done_n;
  logic                  busy_n;

  logic                  accept_en;
  logic                  hs;
  logic                  start_ok;
  logic [PIX_WIDTH-1:0]  src_pix;

  assign accept_en  = (state == EMBED) || (state == PASS);
  assign hs         = pix_in_valid && pix_in_ready;
  assign start_ok   = start && ((state == IDLE) || (state == PASS));
  // One read per FETCH visit; FETCH always leaves on the read.
  assign sec_rd_req = (state == FETCH) && !sec_empty;

  // Replace the pixel LSBs with the top BPP bits of the nibble register.
  assign src_pix = (state == EMBED)
                 ? {pix_in[PIX_WIDTH-1:BPP], nib_reg[MESS_WIDTH-1 -: BPP]}
                 : pix_in;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      remaining    <= '0;
      embedded_cnt <= '0;
      nib_reg      <= '0;
      slice_cnt    <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      remaining    <= remaining_n;
      embedded_cnt <= embedded_n;
      nib_reg      <= nib_n;
      slice_cnt    <= slice_n;
      done         <= done_n;
      busy         <= busy_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    embedded_n  = embedded_cnt;
    nib_n       = nib_reg;
    slice_n     = slice_cnt;
    done_n      = 1'b0;

    unique case (state)
      IDLE: ;
      FETCH: begin
        if (sec_rd_req) state_n = LOAD;
      end
      LOAD: begin
        nib_n   = sec_dout;
        slice_n = SLICE_W'(SLICES);
        state_n = EMBED;
      end
      EMBED: begin
        if (hs) begin
          nib_n   = nib_reg << BPP;
          slice_n = slice_cnt - SLICE_W'(1);
          if (slice_cnt == SLICE_W'(1)) begin
            embedded_n  = embedded_cnt + LEN_WIDTH'(1);
            remaining_n = remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              done_n  = 1'b1;
              state_n = PASS;
            end else begin
              state_n = FETCH;
            end
          end
        end
      end
      PASS: ;
      default: state_n = IDLE;
    endcase

    // A new message may start from IDLE or after the previous one finished.
    if (start_ok) begin
      remaining_n = msg_len;
      embedded_n  = '0;
      if (msg_len != '0) begin
        state_n = FETCH;
      end else begin
        state_n = PASS;
        done_n  = 1'b1;
      end
    end

    busy_n = (state_n == FETCH) || (state_n == LOAD) || (state_n == EMBED);
  end

  stego_pix_reg #(
    .PIX_WIDTH (PIX_WIDTH)
  ) u_pix_reg (
    .clk        (clk),
    .rst        (rst),
    .accept_en  (accept_en),
    .src_pix    (src_pix),
    .src_valid  (pix_in_valid),
    .src_ready  (pix_in_ready),
    .pix        (pix_out),
    .pix_valid  (pix_out_valid),
    .sink_ready (pix_out_ready)
  );

endmodule

// File: tb/tb_stego_lsb_embed.sv
// Scoreboard bench for stego_lsb_embed: stimulus pushes expected stego
// pixels, a negedge monitor pops and compares on each output transfer.
module tb_stego_lsb_embed;

  localparam int PW  = 8;
  localparam int MW  = 4;
  localparam int BPP = 2;
  localparam int LW  = 16;
  localparam int SPN = MW / BPP;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] msg_len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] embedded_cnt;
  logic [MW-1:0] sec_dout = '0;
  logic          sec_empty = 1'b1;
  logic          sec_rd_req;
  logic [PW-1:0] pix_in = '0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_ready;
  logic [PW-1:0] pix_out;
  logic          pix_out_valid;
  logic          pix_out_ready = 1'b1;

  stego_lsb_embed #(
    .PIX_WIDTH (PW),
    .MESS_WIDTH(MW),
    .BPP       (BPP),
    .LEN_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg_len      (msg_len),
    .busy         (busy),
    .done         (done),
    .embedded_cnt (embedded_cnt),
    .sec_dout     (sec_dout),
    .sec_empty    (sec_empty),
    .sec_rd_req   (sec_rd_req),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .pix_out      (pix_out),
    .pix_out_valid(pix_out_valid),
    .pix_out_ready(pix_out_ready)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cycle    = 0;
  int done_due = -10;
  int done_pulses = 0;
  int rd_pulses   = 0;
  int ready_mode  = 0;   // 0: always ready, 1: random, 2: stalled
  bit hold_empty  = 1'b0;

  logic [PW-1:0] exp_q[$];
  logic [MW-1:0] fifo_q[$];
  int            mdl_msg[$];
  int            mdl_idx = 0;
  int            mdl_total = 0;

  task automatic check(input string name, input longint act, input longint req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Downstream ready pattern.
  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       pix_out_ready = 1'b1;
      1:       pix_out_ready = 1'($urandom_range(0, 1));
      default: pix_out_ready = 1'b0;
    endcase
  end

  // Secret FIFO model: data appears the cycle after an accepted read.
  always begin : fifo_model
    bit take;
    @(negedge clk);
    take = rst && sec_rd_req;
    @(posedge clk); #2;
    if (take) begin
      if (fifo_q.size() > 0) sec_dout = fifo_q.pop_front();
      else check("fifo_underflow", 1, 0);
    end
    sec_empty = hold_empty || (fifo_q.size() == 0);
  end

  // Output monitor and protocol checks.
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_rd = 1'b0, prev_rst = 1'b0;
  logic [PW-1:0] prev_pix = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (pix_out_valid && pix_out_ready) begin
        if (exp_q.size() == 0) check("pix_out_unexpected", 1, 0);
        else check("pix_out", pix_out, exp_q.pop_front());
      end
      if (prev_rst && prev_v && !prev_r) begin
        check("hold_valid", pix_out_valid, 1);
        check("hold_pix", pix_out, prev_pix);
      end
      if (sec_rd_req) begin
        rd_pulses++;
        check("rd_back_to_back", prev_rd, 0);
      end
      if (done || cycle == done_due) check("done_timing", done, (cycle == done_due) ? 1 : 0);
      if (done) done_pulses++;
    end
    prev_v   = pix_out_valid;
    prev_r   = pix_out_ready;
    prev_pix = pix_out;
    prev_rd  = sec_rd_req && rst;
    prev_rst = rst;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_msg();
    mdl_msg.delete();
  endtask

  task automatic load_nib(input int v);
    fifo_q.push_back(MW'(v));
    mdl_msg.push_back(v);
  endtask

  task automatic start_msg(input int len);
    mdl_idx   = 0;
    mdl_total = len * SPN;
    start     = 1'b1;
    msg_len   = LW'(len);
    @(negedge clk);
    if (len == 0) done_due = cycle + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one cover pixel; expected output comes from the bit-stream model
  // unless a fixed value (want >= 0) is given.
  task automatic send_pix(input int p, input int want);
    int t, e, nib, s, bits;
    bit acc;
    t = 0; acc = 1'b0;
    pix_in = PW'(p);
    pix_in_valid = 1'b1;
    while (!acc && t < 300) begin
      @(negedge clk);
      if (pix_in_ready) acc = 1'b1;
      else begin @(posedge clk); #1; t++; end
    end
    if (!acc) begin
      check("send_timeout", 0, 1);
      pix_in_valid = 1'b0;
      return;
    end
    if (mdl_idx < mdl_total) begin
      nib  = mdl_msg[mdl_idx / SPN];
      s    = mdl_idx % SPN;
      bits = (nib >> (MW - BPP * (s + 1))) % (1 << BPP);
      e    = (p / (1 << BPP)) * (1 << BPP) + bits;
      if (mdl_idx == mdl_total - 1) done_due = cycle + 1;
    end else begin
      e = p;
    end
    mdl_idx++;
    if (want >= 0) e = want;
    exp_q.push_back(PW'(e));
    @(posedge clk); #1;
    pix_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pix_out_valid) && t < 500) begin
      @(negedge clk); t++;
    end
    if (t >= 500) check("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  int d0, r0, len, n;
  logic [PW-1:0] bp_hold;

  initial begin
    // Reset with random inputs toggling.
    rst = 1'b0;
    ready_mode = 1;
    repeat (3) begin
      @(posedge clk); #1;
      start        = 1'($urandom_range(0, 1));
      msg_len      = LW'($urandom_range(0, 7));
      pix_in       = PW'($urandom_range(0, 255));
      pix_in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_pix_out", pix_out, 0);
      check("rst_pix_out_valid", pix_out_valid, 0);
      check("rst_done", done, 0);
      check("rst_embedded_cnt", embedded_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_sec_rd_req", sec_rd_req, 0);
      check("rst_pix_in_ready", pix_in_ready, 0);
    end
    @(posedge clk); #1;
    start = 1'b0; pix_in_valid = 1'b0; ready_mode = 0;
    rst = 1'b1;
    tick(2);

    // Nominal: nibbles A,5 into FF,FF,00,00 then a passthrough pixel.
    clear_msg(); load_nib(4'hA); load_nib(4'h5);
    d0 = done_pulses; r0 = rd_pulses;
    tick(1);
    start_msg(2);
    check("nom_busy", busy, 1);
    send_pix(8'hFF, 8'hFE);
    send_pix(8'hFF, 8'hFE);
    send_pix(8'h00, 8'h01);
    send_pix(8'h00, 8'h01);
    send_pix(8'h10, 8'h10);
    drain();
    check("nom_done_pulses", done_pulses - d0, 1);
    check("nom_embedded_cnt", embedded_cnt, 2);
    check("nom_rd_pulses", rd_pulses - r0, 2);
    check("nom_busy_after", busy, 0);

    // FIFO empty while fetching: cover stream must stall.
    hold_empty = 1'b1;
    clear_msg(); load_nib($urandom_range(0, 15));
    tick(2);
    d0 = done_pulses; r0 = rd_pulses;
    start_msg(1);
    fork
      begin
        send_pix($urandom_range(0, 255), -1);
        send_pix($urandom_range(0, 255), -1);
      end
    join_none
    repeat (20) begin
      @(negedge clk);
      check("stall_rd_req", sec_rd_req, 0);
      check("stall_pix_in_ready", pix_in_ready, 0);
    end
    hold_empty = 1'b0;
    wait fork;
    drain();
    check("stall_rd_pulses", rd_pulses - r0, 1);
    check("stall_embedded_cnt", embedded_cnt, 1);
    check("stall_done_pulses", done_pulses - d0, 1);

    // Downstream backpressure mid-embed.
    clear_msg(); load_nib($urandom_range(0, 15)); load_nib($urandom_range(0, 15));
    ready_mode = 2;
    d0 = done_pulses;
    tick(1);
    start_msg(2);
    fork
      begin
        for (int i = 0; i < 4; i++) send_pix($urandom_range(0, 255), -1);
      end
    join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_out_valid && n < 50);
    check("bp_first_valid", pix_out_valid, 1);
    bp_hold = pix_out;
    repeat (5) begin
      @(negedge clk);
      check("bp_pix_in_ready", pix_in_ready, 0);
      check("bp_pix_out_valid", pix_out_valid, 1);
      check("bp_pix_out_held", pix_out, bp_hold);
    end
    ready_mode = 0;
    wait fork;
    drain();
    check("bp_embedded_cnt", embedded_cnt, 2);
    check("bp_done_pulses", done_pulses - d0, 1);

    // Zero-length message: immediate done, pure passthrough.
    d0 = done_pulses; r0 = rd_pulses;
    start_msg(0);
    send_pix(8'h37, 8'h37);
    drain();
    check("zero_rd_pulses", rd_pulses - r0, 0);
    check("zero_done_pulses", done_pulses - d0, 1);
    check("zero_embedded_cnt", embedded_cnt, 0);

    // Random messages with random gaps and downstream stalls.
    ready_mode = 1;
    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 5);
      clear_msg();
      for (int i = 0; i < len; i++) load_nib($urandom_range(0, 15));
      tick(1);
      d0 = done_pulses; r0 = rd_pulses;
      start_msg(len);
      n = len * SPN + $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        tick($urandom_range(0, 2));
        send_pix($urandom_range(0, 255), -1);
      end
      drain();
      check("rnd_embedded_cnt", embedded_cnt, len);
      check("rnd_done_pulses", done_pulses - d0, 1);
      check("rnd_rd_pulses", rd_pulses - r0, len);
    end

    // Reset after the first of two slices of a nibble.
    ready_mode = 2;
    clear_msg(); load_nib($urandom_range(0, 15)); load_nib($urandom_range(0, 15));
    tick(1);
    start_msg(2);
    send_pix($urandom_range(0, 255), -1);
    rst = 1'b0;
    @(posedge clk);
    exp_q.delete(); fifo_q.delete(); done_due = -10;
    @(negedge clk);
    check("midrst_pix_out_valid", pix_out_valid, 0);
    check("midrst_embedded_cnt", embedded_cnt, 0);
    check("midrst_sec_rd_req", sec_rd_req, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    ready_mode = 0;
    tick(2);

    // Recovery after reset.
    clear_msg(); load_nib($urandom_range(0, 15));
    tick(1);
    d0 = done_pulses;
    start_msg(1);
    send_pix($urandom_range(0, 255), -1);
    send_pix($urandom_range(0, 255), -1);
    send_pix($urandom_range(0, 255), -1);
    drain();
    check("rec_embedded_cnt", embedded_cnt, 1);
    check("rec_done_pulses", done_pulses - d0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
